// File: rtl/imem_load_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory loader/fetch controller,
// also used by the memory and the CPU top.
package imem_load_fetch_ctrl_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 10;

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_e;

endpackage

// File: rtl/imem_bus_driver.sv
// Address/write-enable mux and tristate drive of the shared memory data bus,
// selected by the current load or fetch grant.
module imem_bus_driver
   import imem_load_fetch_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = imem_load_fetch_ctrl_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = imem_load_fetch_ctrl_pkg::ADDR_WIDTH
) (
   input  logic                  rst,
   input  logic                  fetch_grant,
   input  logic                  load_grant,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   input  logic [ADDR_WIDTH-1:0] wr_ptr,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   inout  wire  [DATA_WIDTH-1:0] mem_dados
);

   // Select address and write strobe; with no grant a harmless read of word 0.
   always_comb begin
      mem_addr = {ADDR_WIDTH{1'b0}};
      mem_we   = 1'b0;
      if (load_grant) begin
         mem_addr = wr_ptr;
         mem_we   = ~rst;
      end else if (fetch_grant) begin
         mem_addr = fetch_addr;
         mem_we   = 1'b0;
      end else begin
         mem_addr = {ADDR_WIDTH{1'b0}};
         mem_we   = 1'b0;
      end
   end

   // The memory owns the bus whenever we is low.
   assign mem_dados = mem_we ? load_data : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/imem_load_fetch_ctrl.sv
// Arbiter/sequencer for the single-port instruction memory: boot-loader writes
// versus CPU fetch reads, with a one-cycle turnaround after every read.
module imem_load_fetch_ctrl
   import imem_load_fetch_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = imem_load_fetch_ctrl_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = imem_load_fetch_ctrl_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic                  load_done,
   output logic                  load_ovf,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_ready,
   output logic                  fetch_rvalid,
   output logic [DATA_WIDTH-1:0] fetch_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   inout  wire  [DATA_WIDTH-1:0] mem_dados
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic                    rd_pend_q, rd_pend_d;
   logic                    fetch_rvalid_q, fetch_rvalid_d;
   logic [DATA_WIDTH-1:0]   fetch_rdata_q, fetch_rdata_d;
   logic                    load_done_q, load_done_d;
   logic                    load_ovf_q, load_ovf_d;
   logic                    fetch_grant;
   logic                    load_grant;

   // A write may not start while the memory is still driving a read result.
   assign fetch_ready = (state_q == RUN);
   assign load_ready  = (state_q == LOAD) && !rd_pend_q;
   assign fetch_grant = fetch_req && fetch_ready;
   assign load_grant  = load_valid && load_ready;

   assign load_done    = load_done_q;
   assign load_ovf     = load_ovf_q;
   assign fetch_rvalid = fetch_rvalid_q;
   assign fetch_rdata  = fetch_rdata_q;

   imem_bus_driver #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_bus_driver (
      .rst         (rst),
      .fetch_grant (fetch_grant),
      .load_grant  (load_grant),
      .fetch_addr  (fetch_addr),
      .wr_ptr      (wr_ptr_q),
      .load_data   (load_data),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_dados   (mem_dados)
   );

   // Next-state logic for the FSM, write pointer and read pipeline.
   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      load_ovf_d     = load_ovf_q;
      load_done_d    = 1'b0;
      rd_pend_d      = fetch_grant;
      fetch_rvalid_d = rd_pend_q;
      if (rd_pend_q) begin
         fetch_rdata_d = mem_dados;
      end else begin
         fetch_rdata_d = fetch_rdata_q;
      end
      case (state_q)
         RUN: begin
            if (load_start) begin
               state_d    = LOAD;
               wr_ptr_d   = {ADDR_WIDTH{1'b0}};
               load_ovf_d = 1'b0;
            end else begin
               state_d    = RUN;
            end
         end
         LOAD: begin
            if (load_grant) begin
               wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
               if (&wr_ptr_q) begin
                  load_ovf_d = 1'b1;
               end else begin
                  load_ovf_d = load_ovf_q;
               end
               if (load_last) begin
                  state_d     = RUN;
                  load_done_d = 1'b1;
               end else begin
                  state_d     = LOAD;
               end
            end else begin
               state_d = LOAD;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State registers; reset drops any pending read and abandons a load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= RUN;
         wr_ptr_q       <= {ADDR_WIDTH{1'b0}};
         rd_pend_q      <= 1'b0;
         fetch_rvalid_q <= 1'b0;
         fetch_rdata_q  <= {DATA_WIDTH{1'b0}};
         load_done_q    <= 1'b0;
         load_ovf_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_pend_q      <= rd_pend_d;
         fetch_rvalid_q <= fetch_rvalid_d;
         fetch_rdata_q  <= fetch_rdata_d;
         load_done_q    <= load_done_d;
         load_ovf_q     <= load_ovf_d;
      end
   end

endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// Directed bench for imem_load_fetch_ctrl with a behavioural single-port memory
// that tristates its output while we is high.
module tb_imem_load_fetch_ctrl;

   localparam int DW = 32;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_start = 1'b0;
   logic          load_valid = 1'b0;
   logic [DW-1:0] load_data = '0;
   logic          load_last = 1'b0;
   logic          load_ready, load_done, load_ovf;
   logic          fetch_req = 1'b0;
   logic [AW-1:0] fetch_addr = '0;
   logic          fetch_ready, fetch_rvalid;
   logic [DW-1:0] fetch_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   wire  [DW-1:0] mem_dados;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] mem_q;
   int            pass_cnt = 0;
   int            total_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_dados;
      mem_q <= mem[mem_addr];
   end
   assign mem_dados = mem_we ? {DW{1'bz}} : mem_q;

   imem_load_fetch_ctrl dut (
      .clk(clk), .rst(rst),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
      .load_ovf(load_ovf), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_dados(mem_dados)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      fetch_req = 1'b0; fetch_addr = '0;
   endtask

   task automatic test_reset();
      tick(); tick();
      total_cnt++; if ({fetch_rvalid, load_done, load_ovf, mem_we} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {fetch_rvalid, load_done, load_ovf, mem_we}); else pass_cnt++;
      total_cnt++; if (fetch_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", fetch_rdata); else pass_cnt++;
      total_cnt++; if ({fetch_ready, load_ready} !== 2'b10) $display("FAIL reset_ready: got %b want 10", {fetch_ready, load_ready}); else pass_cnt++;
      rst = 1'b0;
      tick();
      total_cnt++; if ({mem_we, mem_addr} !== {1'b0, 10'd0}) $display("FAIL idle_bus: got we=%b addr=%0d want we=0 addr=0", mem_we, mem_addr); else pass_cnt++;
   endtask

   task automatic test_load();
      logic [DW-1:0] words [4];
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      total_cnt++; if ({fetch_ready, load_ready} !== 2'b01) $display("FAIL load_enter: got %b want 01", {fetch_ready, load_ready}); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1; load_data = words[i]; load_last = (i == 3);
         #1;
         total_cnt++; if ({mem_we, mem_addr, mem_dados} !== {1'b1, 10'(i), words[i]}) $display("FAIL load_beat%0d: got we=%b addr=%0d d=%h want we=1 addr=%0d d=%h", i, mem_we, mem_addr, mem_dados, i, words[i]); else pass_cnt++;
         tick();
         if (i < 3) begin
            total_cnt++; if (load_done !== 1'b0) $display("FAIL load_done_early%0d: got %b want 0", i, load_done); else pass_cnt++;
         end
      end
      idle_inputs();
      total_cnt++; if ({load_done, fetch_ready} !== 2'b11) $display("FAIL load_done_pulse: got %b want 11", {load_done, fetch_ready}); else pass_cnt++;
      tick();
      total_cnt++; if (load_done !== 1'b0) $display("FAIL load_done_once: got %b want 0", load_done); else pass_cnt++;
      total_cnt++; if ({mem[0], mem[1], mem[2], mem[3]} !== {32'h11, 32'h22, 32'h33, 32'h44}) $display("FAIL load_mem: got %h %h %h %h want 11 22 33 44", mem[0], mem[1], mem[2], mem[3]); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_d [4];
      exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
      for (int c = 0; c < 7; c++) begin
         if (c < 4) begin
            fetch_req = 1'b1; fetch_addr = 10'(c);
            #1;
            total_cnt++; if ({fetch_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 10'(c)}) $display("FAIL fetch_grant%0d: got rdy=%b we=%b addr=%0d want 1 0 %0d", c, fetch_ready, mem_we, mem_addr, c); else pass_cnt++;
         end else begin
            idle_inputs();
         end
         if (c >= 2 && c < 6) begin
            total_cnt++; if ({fetch_rvalid, fetch_rdata} !== {1'b1, exp_d[c-2]}) $display("FAIL fetch_data%0d: got v=%b d=%h want v=1 d=%h", c, fetch_rvalid, fetch_rdata, exp_d[c-2]); else pass_cnt++;
         end else begin
            total_cnt++; if (fetch_rvalid !== 1'b0) $display("FAIL fetch_novalid%0d: got %b want 0", c, fetch_rvalid); else pass_cnt++;
         end
         tick();
      end
      total_cnt++; if (fetch_rdata !== 32'h44) $display("FAIL rdata_hold: got %h want 44", fetch_rdata); else pass_cnt++;
   endtask

   task automatic test_turnaround();
      fetch_req = 1'b1; fetch_addr = 10'd2; load_start = 1'b1;
      #1;
      total_cnt++; if ({fetch_ready, mem_addr, mem_we} !== {1'b1, 10'd2, 1'b0}) $display("FAIL turn_fetch: got rdy=%b addr=%0d we=%b want 1 2 0", fetch_ready, mem_addr, mem_we); else pass_cnt++;
      tick();
      idle_inputs();
      load_valid = 1'b1; load_data = 32'h55;
      #1;
      total_cnt++; if ({load_ready, mem_we, fetch_ready} !== 3'b000) $display("FAIL turn_bubble: got %b want 000", {load_ready, mem_we, fetch_ready}); else pass_cnt++;
      tick();
      load_last = 1'b1;
      #1;
      total_cnt++; if ({fetch_rvalid, fetch_rdata} !== {1'b1, 32'h33}) $display("FAIL turn_rvalid: got v=%b d=%h want v=1 d=33", fetch_rvalid, fetch_rdata); else pass_cnt++;
      total_cnt++; if ({load_ready, mem_we, mem_addr} !== {1'b1, 1'b1, 10'd0}) $display("FAIL turn_write: got rdy=%b we=%b addr=%0d want 1 1 0", load_ready, mem_we, mem_addr); else pass_cnt++;
      tick();
      idle_inputs();
      total_cnt++; if ({load_done, mem[0]} !== {1'b1, 32'h55}) $display("FAIL turn_done: got done=%b m0=%h want 1 55", load_done, mem[0]); else pass_cnt++;
      tick();
   endtask

   task automatic test_fetch_during_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      fetch_req = 1'b1; fetch_addr = 10'd5;
      #1;
      total_cnt++; if ({fetch_ready, mem_we, mem_addr} !== {1'b0, 1'b0, 10'd0}) $display("FAIL fdl_blocked: got rdy=%b we=%b addr=%0d want 0 0 0", fetch_ready, mem_we, mem_addr); else pass_cnt++;
      tick();
      load_valid = 1'b1; load_data = 32'hCAFE_0001; load_last = 1'b1;
      #1;
      total_cnt++; if (fetch_rvalid !== 1'b0) $display("FAIL fdl_no_read: got %b want 0", fetch_rvalid); else pass_cnt++;
      total_cnt++; if ({fetch_ready, mem_we, mem_dados} !== {1'b0, 1'b1, 32'hCAFE_0001}) $display("FAIL fdl_write: got rdy=%b we=%b d=%h want 0 1 cafe0001", fetch_ready, mem_we, mem_dados); else pass_cnt++;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_wrap();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i <= (1 << AW); i++) begin
         load_valid = 1'b1; load_data = 32'hA000_0000 + i; load_last = (i == (1 << AW));
         #1;
         if (i == (1 << AW) - 1) begin
            total_cnt++; if ({load_ovf, mem_addr} !== {1'b0, 10'h3FF}) $display("FAIL wrap_before: got ovf=%b addr=%0d want 0 1023", load_ovf, mem_addr); else pass_cnt++;
         end
         if (i == (1 << AW)) begin
            total_cnt++; if ({load_ovf, mem_addr, mem_we} !== {1'b1, 10'd0, 1'b1}) $display("FAIL wrap_last: got ovf=%b addr=%0d we=%b want 1 0 1", load_ovf, mem_addr, mem_we); else pass_cnt++;
         end
         tick();
      end
      idle_inputs();
      total_cnt++; if ({load_done, load_ovf} !== 2'b11) $display("FAIL wrap_done: got %b want 11", {load_done, load_ovf}); else pass_cnt++;
      total_cnt++; if ({mem[0], mem[1], mem[1023]} !== {32'hA000_0400, 32'hA000_0001, 32'hA000_03FF}) $display("FAIL wrap_mem: got %h %h %h", mem[0], mem[1], mem[1023]); else pass_cnt++;
      tick(); tick();
      total_cnt++; if (load_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", load_ovf); else pass_cnt++;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      total_cnt++; if (load_ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", load_ovf); else pass_cnt++;
      load_valid = 1'b1; load_data = 32'h77; load_last = 1'b1;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      fetch_req = 1'b1; fetch_addr = 10'd1;
      tick();
      idle_inputs();
      rst = 1'b1;
      #1;
      total_cnt++; if ({fetch_rvalid, load_done, load_ovf, mem_we, fetch_rdata} !== {4'b0000, 32'h0}) $display("FAIL rst_async: got flags=%b d=%h want 0000 0", {fetch_rvalid, load_done, load_ovf, mem_we}, fetch_rdata); else pass_cnt++;
      tick();
      total_cnt++; if (fetch_rvalid !== 1'b0) $display("FAIL rst_drop_read: got %b want 0", fetch_rvalid); else pass_cnt++;
      rst = 1'b0;
      tick();
      total_cnt++; if (fetch_rvalid !== 1'b0) $display("FAIL rst_no_late_rvalid: got %b want 0", fetch_rvalid); else pass_cnt++;
      load_start = 1'b1;
      tick();
      load_start = 1'b0; load_valid = 1'b1; load_data = 32'h99;
      #1;
      total_cnt++; if (mem_we !== 1'b1) $display("FAIL rst_pre_load: got %b want 1", mem_we); else pass_cnt++;
      rst = 1'b1;
      #1;
      total_cnt++; if ({mem_we, load_ready, fetch_ready} !== 3'b001) $display("FAIL rst_abandon_load: got %b want 001", {mem_we, load_ready, fetch_ready}); else pass_cnt++;
      tick();
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_turnaround();
      test_fetch_during_load();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
